// File: rtl/nios2_gpio_ext.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear, synchronised inputs, W1C edge capture, level irq.
// Optional input debouncer is compiled in with `define GPIO_DEBOUNCE_EN.
module nios2_gpio_ext #(
   parameter int WIDTH        = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_DIV = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   inout  wire  [WIDTH-1:0]  bidir_port
);

   typedef enum logic [2:0] {
      REG_DATA = 3'd0,
      REG_DIR  = 3'd1,
      REG_MASK = 3'd2,
      REG_EDGE = 3'd3,
      REG_SET  = 3'd4,
      REG_CLR  = 3'd5,
      REG_RISE = 3'd6,
      REG_FALL = 3'd7
   } reg_addr_t;

   localparam int PRIME_CNT = SYNC_STAGES + 1;
   localparam int PRIME_W   = $clog2(PRIME_CNT + 1);

   logic [WIDTH-1:0]   data_out, dir, irq_mask, edge_cap, rise_en, fall_en;
   logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]   sync_in, cond_in, prev_in, detect, cap_clr, wdata;
   logic [PRIME_W-1:0] prime_cnt;
   logic               primed, wr;
   logic [31:0]        rd_mux;
   reg_addr_t          addr;

   assign addr    = reg_addr_t'(address);
   assign wr      = chipselect & ~write_n;
   assign wdata   = writedata[WIDTH-1:0];
   assign sync_in = sync_q[SYNC_STAGES-1];

   for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
   end

   always_ff @(posedge clk) begin
      // NOTE: the chain is plain flops, not a RAM, so every stage can be reset; this keeps DATA at 0 out of reset.
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= bidir_port;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int DIV_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [WIDTH-1:0] hist1, hist2, stable;

   assign tick = (div_cnt == DIV_W'(DEBOUNCE_DIV - 1));

   // stable follows a bit only once the current and two previous tick samples all agree
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         hist1   <= '0;
         hist2   <= '0;
         stable  <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            hist1  <= sync_in;
            hist2  <= hist1;
            stable <= (sync_in & hist1 & hist2) | (stable & (sync_in | hist1 | hist2));
         end
      end
   end

   assign cond_in = stable;
`else
   assign cond_in = sync_in;
`endif

   assign primed  = (prime_cnt == PRIME_W'(PRIME_CNT));
   assign detect  = primed ? ((cond_in & ~prev_in & rise_en) | (~cond_in & prev_in & fall_en)) : '0;
   assign cap_clr = (wr && addr == REG_EDGE) ? wdata : '0;
   assign irq     = |(edge_cap & irq_mask);

   always_comb begin
      // NOTE: default first so every path assigns rd_mux and no latch is inferred.
      rd_mux = '0;
      case (addr)
         REG_DATA: rd_mux = 32'(cond_in);
         REG_DIR:  rd_mux = 32'(dir);
         REG_MASK: rd_mux = 32'(irq_mask);
         REG_EDGE: rd_mux = 32'(edge_cap);
         REG_RISE: rd_mux = 32'(rise_en);
         REG_FALL: rd_mux = 32'(fall_en);
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      if (reset) begin
         data_out  <= '0;
         dir       <= '0;
         irq_mask  <= '0;
         edge_cap  <= '0;
         rise_en   <= '0;
         fall_en   <= '0;
         prev_in   <= '0;
         prime_cnt <= '0;
         readdata  <= '0;
      end else begin
         prev_in  <= cond_in;
         readdata <= rd_mux;
         if (!primed) prime_cnt <= prime_cnt + 1'b1;
         // a fresh edge outranks a simultaneous clear of the same bit
         edge_cap <= (edge_cap & ~cap_clr) | detect;
         if (wr) begin
            case (addr)
               REG_DATA: data_out <= wdata;
               REG_DIR:  dir      <= wdata;
               REG_MASK: irq_mask <= wdata;
               REG_SET:  data_out <= data_out | wdata;
               REG_CLR:  data_out <= data_out & ~wdata;
               REG_RISE: rise_en  <= wdata;
               REG_FALL: fall_en  <= wdata;
               default:  ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nios2_gpio_ext.sv
// Directed bench for nios2_gpio_ext (WIDTH=8); expected read data queued at issue, checked on return.
module tb_nios2_gpio_ext;

   localparam int W  = 8;
   localparam int SS = 2;
`ifdef GPIO_DEBOUNCE_EN
   localparam int SETTLE = 24;
   localparam int LAT    = 24;
`else
   localparam int SETTLE = 5;
   localparam int LAT    = SS + 1;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [2:0]    address = '0;
   logic          chipselect = 1'b0;
   logic          write_n = 1'b1;
   logic [31:0]   writedata = '0;
   logic [31:0]   readdata;
   logic          irq;
   wire  [W-1:0]  bidir_port;
   logic [W-1:0]  pin_val = '0;
   logic [W-1:0]  pin_oe  = '1;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [31:0]   exp_q[$];

   for (genvar i = 0; i < W; i++) begin : g_drv
      assign bidir_port[i] = pin_oe[i] ? pin_val[i] : 1'bz;
   end

   nios2_gpio_ext #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_DIV(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .bidir_port (bidir_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] e);
      address = a;
      exp_q.push_back(e);
      @(negedge clk);
      check(tag, readdata, exp_q.pop_front());
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_pins(input logic [W-1:0] v);
      pin_val = v;
      pin_oe  = '1;
   endtask

   task automatic wait_irq(input string tag, input logic level, input int bound);
      int i;
      i = 0;
      while (irq !== level && i < bound) begin
         @(negedge clk);
         i++;
      end
      check(tag, {31'b0, irq}, {31'b0, level});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_pins(8'h00);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      check("rst_irq", {31'b0, irq}, 32'h0);
      for (int a = 0; a < 8; a++) rd($sformatf("rst_rd%0d", a), 3'(a), 32'h0);

      // DUT must not drive pins after reset: an external pattern reads back intact
      drive_pins(8'h5A);
      idle(SETTLE);
      rd("hiz_data", 3'd0, 32'h5A);

      pin_oe = '0;
      wr(3'd1, 32'hFFFF_FFFF);
      rd("dir_wide", 3'd1, 32'h0000_00FF);
      wr(3'd0, 32'hA5);
      wr(3'd4, 32'h0A);
      check("pins_set", 32'(bidir_port), 32'hAF);
      idle(SETTLE);
      rd("data_set", 3'd0, 32'hAF);
      rd("set_rd0", 3'd4, 32'h0);
      wr(3'd5, 32'h81);
      check("pins_clr", 32'(bidir_port), 32'h2E);
      idle(SETTLE);
      rd("data_clr", 3'd0, 32'h2E);
      rd("clr_rd0", 3'd5, 32'h0);

      wr(3'd1, 32'h0);
      drive_pins(8'h02);
      idle(SETTLE);
      wr(3'd6, 32'h01);
      wr(3'd7, 32'h02);
      wr(3'd2, 32'h03);
      rd("cap_clean", 3'd3, 32'h0);
      check("irq_clean", {31'b0, irq}, 32'h0);

      drive_pins(8'h03);
      wait_irq("rise_irq", 1'b1, LAT);
      rd("cap_rise", 3'd3, 32'h01);
      drive_pins(8'h01);
      idle(SETTLE);
      rd("cap_fall", 3'd3, 32'h03);
      drive_pins(8'h00);
      idle(SETTLE);
      rd("cap_nofall0", 3'd3, 32'h03);

      wr(3'd3, 32'h01);
      rd("w1c_bit0", 3'd3, 32'h02);
      check("irq_hold", {31'b0, irq}, 32'h1);
      wr(3'd3, 32'h02);
      check("irq_drop", {31'b0, irq}, 32'h0);
      rd("w1c_bit1", 3'd3, 32'h0);

`ifndef GPIO_DEBOUNCE_EN
      // clear of bit0 lands on the same edge that captures the new rise
      drive_pins(8'h01);
      idle(2);
      wr(3'd3, 32'h01);
      rd("set_wins", 3'd3, 32'h01);
`else
      drive_pins(8'h01);
      idle(SETTLE);
`endif
      wr(3'd3, 32'hFF);
      rd("cap_cleared", 3'd3, 32'h0);

      // reset with pins high, plus a concurrent DIR write that reset must override
      drive_pins(8'hFF);
      reset      = 1'b1;
      address    = 3'd1;
      writedata  = 32'hFF;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wr(3'd6, 32'hFF);
      idle(6);
      rd("prime_cap", 3'd3, 32'h0);
      check("prime_irq", {31'b0, irq}, 32'h0);
      rd("rst_over_wr", 3'd1, 32'h0);
      rd("rise_en_rd", 3'd6, 32'hFF);
      idle(SETTLE);
      wr(3'd3, 32'hFF);

      drive_pins(8'hFE);
      idle(SETTLE);
      drive_pins(8'hFF);
      idle(SETTLE);
      rd("post_prime", 3'd3, 32'h01);
      wr(3'd3, 32'hFF);

`ifdef GPIO_DEBOUNCE_EN
      drive_pins(8'hFB);
      idle(SETTLE);
      wr(3'd3, 32'hFF);
      rd("db_clean", 3'd3, 32'h0);
      drive_pins(8'hFF);
      idle(6);
      drive_pins(8'hFB);
      idle(SETTLE);
      rd("db_glitch", 3'd3, 32'h0);
      drive_pins(8'hFF);
      idle(16);
      rd("db_hold", 3'd3, 32'h04);
      rd("db_data", 3'd0, 32'hFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
